// File: rtl/requant_result_writer.sv
// Packs int8 result lanes into SRAM words, buffers them in a
// fall-through FIFO and streams them to output SRAM.
module requant_result_writer #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 8,
  parameter int SRAM_WIDTH = 64,
  parameter int ADDR_WIDTH = 18,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [ADDR_WIDTH-1:0]               base_addr,
  input  logic [ADDR_WIDTH-1:0]               total_elems,
  input  logic                                in_valid,
  input  logic [LANES*DATA_WIDTH-1:0]         in_data,
  input  logic [$clog2(LANES+1)-1:0]          in_num_groups,
  output logic                                sram_wr_en,
  input  logic                                sram_wr_ready,
  output logic [ADDR_WIDTH-1:0]               sram_wr_addr,
  output logic [SRAM_WIDTH-1:0]               sram_wr_data,
  output logic [SRAM_WIDTH/DATA_WIDTH-1:0]    sram_wr_mask,
  output logic                                busy,
  output logic                                done,
  output logic                                overflow
);
  localparam int BPW = SRAM_WIDTH / DATA_WIDTH;
  localparam int GW  = $clog2(LANES + 1);
  localparam int FW  = $clog2(2 * BPW);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int BW  = 2 * SRAM_WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DRAIN} state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] rem_q, rem_d;
  logic [BW-1:0]         buf_q, buf_d;
  logic [FW-1:0]         fill_q, fill_d;
  logic                  busy_q, done_q, ovf_q;
  logic [PW-1:0]         wp_q, rp_q;
  logic [PW:0]           cnt_q;

  logic [SRAM_WIDTH-1:0] mem_data [FIFO_DEPTH];
  logic [BPW-1:0]        mem_mask [FIFO_DEPTH];

  logic                  fifo_empty, fifo_full, pop, push, push_req;
  logic                  take, drain_ok;
  logic [SRAM_WIDTH-1:0] push_data;
  logic [BPW-1:0]        push_mask;
  logic [GW-1:0]         n_lim, n;
  logic [LANES*DATA_WIDTH-1:0] beat;
  logic [BW-1:0]         ins;

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == (PW+1)'(FIFO_DEPTH));
  assign pop        = !fifo_empty && sram_wr_ready;
  assign push       = push_req && (!fifo_full || pop);
  assign take       = (state_q == RUN) && in_valid;
  // Finish the cycle the last word leaves, not a cycle later.
  assign drain_ok   = fifo_empty || ((cnt_q == (PW+1)'(1)) && pop);

  always_comb begin
    n_lim = (in_num_groups > GW'(LANES)) ? GW'(LANES) : in_num_groups;
    n     = (rem_q < ADDR_WIDTH'(n_lim)) ? GW'(rem_q) : n_lim;
    beat  = '0;
    for (int k = 0; k < LANES; k++) begin
      if (GW'(k) < n) begin
        beat[k*DATA_WIDTH +: DATA_WIDTH] = in_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    ins = '0;
    ins[LANES*DATA_WIDTH-1:0] = beat;
    ins = ins << (fill_q * DATA_WIDTH);
    buf_d     = buf_q;
    fill_d    = fill_q;
    rem_d     = rem_q;
    push_req  = 1'b0;
    push_data = '0;
    push_mask = '0;
    if (take) begin
      buf_d  = buf_q | ins;
      fill_d = fill_q + FW'(n);
      rem_d  = rem_q - ADDR_WIDTH'(n);
      if (fill_d >= FW'(BPW)) begin
        push_req  = 1'b1;
        push_data = buf_d[SRAM_WIDTH-1:0];
        push_mask = '1;
        buf_d     = buf_d >> SRAM_WIDTH;
        fill_d    = fill_d - FW'(BPW);
      end
    end else if ((state_q == FLUSH) && (fill_q != '0)) begin
      push_req  = 1'b1;
      push_data = buf_q[SRAM_WIDTH-1:0];
      for (int i = 0; i < BPW; i++) begin
        push_mask[i] = (FW'(i) < fill_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wp_q] <= push_data;
      mem_mask[wp_q] <= push_mask;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      buf_q   <= '0;
      fill_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
    end else begin
      done_q <= 1'b0;
      if (push) wp_q <= wp_q + PW'(1);
      if (pop) begin
        rp_q   <= rp_q + PW'(1);
        addr_q <= addr_q + ADDR_WIDTH'(1);
      end
      cnt_q <= cnt_q + (PW+1)'(push) - (PW+1)'(pop);
      if (push_req && fifo_full && !pop) ovf_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (start && !busy_q) begin
            addr_q  <= base_addr;
            rem_q   <= total_elems;
            buf_q   <= '0;
            fill_q  <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= (total_elems == '0) ? DRAIN : RUN;
          end else if (done_q) begin
            busy_q <= 1'b0;
          end
        end
        RUN: begin
          buf_q  <= buf_d;
          fill_q <= fill_d;
          rem_q  <= rem_d;
          if (take && (rem_d == '0)) state_q <= FLUSH;
        end
        FLUSH: begin
          buf_q  <= '0;
          fill_q <= '0;
          if ((fill_q == '0) && drain_ok) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (drain_ok) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sram_wr_en   = !fifo_empty;
  assign sram_wr_addr = addr_q;
  assign sram_wr_data = fifo_empty ? '0 : mem_data[rp_q];
  assign sram_wr_mask = fifo_empty ? '0 : mem_mask[rp_q];
  assign busy         = busy_q;
  assign done         = done_q;
  assign overflow     = ovf_q;
endmodule

// File: tb/tb_requant_result_writer.sv
// Directed and randomized bench for requant_result_writer with a
// byte-stream reference model.
`timescale 1ns/1ps
module tb_requant_result_writer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [17:0] base_addr = '0;
  logic [17:0] total_elems = '0;
  logic        in_valid = 1'b0;
  logic [63:0] in_data = '0;
  logic [3:0]  in_num_groups = '0;
  logic        sram_wr_en;
  logic        sram_wr_ready = 1'b1;
  logic [17:0] sram_wr_addr;
  logic [63:0] sram_wr_data;
  logic [7:0]  sram_wr_mask;
  logic        busy, done, overflow;

  always #5 clk = ~clk;

  requant_result_writer dut (
    .clk(clk), .rst(rst), .start(start),
    .base_addr(base_addr), .total_elems(total_elems),
    .in_valid(in_valid), .in_data(in_data),
    .in_num_groups(in_num_groups),
    .sram_wr_en(sram_wr_en), .sram_wr_ready(sram_wr_ready),
    .sram_wr_addr(sram_wr_addr), .sram_wr_data(sram_wr_data),
    .sram_wr_mask(sram_wr_mask), .busy(busy), .done(done),
    .overflow(overflow)
  );

  typedef struct packed {
    logic [17:0] a;
    logic [63:0] d;
    logic [7:0]  m;
  } wr_t;
  typedef struct {
    int          g;
    logic [63:0] d;
  } beat_t;

  int    cyc = 0;
  wr_t   obs_q[$];
  int    obs_c[$];
  wr_t   exp_q[$];
  beat_t beats_q[$];
  int    done_n = 0;
  int    done_cyc = 0;
  int    total = 0;
  int    bad = 0;
  bit    rdy_rand = 0;
  logic [17:0] job_base, job_total;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (sram_wr_en && sram_wr_ready) begin
      obs_q.push_back('{sram_wr_addr, sram_wr_data, sram_wr_mask});
      obs_c.push_back(cyc);
    end
    if (done) begin
      done_n++;
      done_cyc = cyc;
    end
  end

  task automatic chk(string tag, logic [127:0] o, logic [127:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, o, e);
    end
  endtask

  function automatic logic [127:0] outs();
    return {sram_wr_en, sram_wr_addr, sram_wr_data, sram_wr_mask,
            busy, done, overflow};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    if (rdy_rand) sram_wr_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic start_job(logic [17:0] b, logic [17:0] t);
    job_base = b;
    job_total = t;
    beats_q.delete();
    obs_q.delete();
    obs_c.delete();
    done_n = 0;
    start = 1'b1;
    base_addr = b;
    total_elems = t;
    step();
    start = 1'b0;
  endtask

  task automatic send(int g, logic [63:0] d);
    in_valid = 1'b1;
    in_num_groups = 4'(g);
    in_data = d;
    beats_q.push_back('{g, d});
    step();
    in_valid = 1'b0;
    in_num_groups = '0;
    in_data = '0;
  endtask

  task automatic wait_done(int budget);
    int k = 0;
    while (done_n == 0 && k < budget) begin
      step();
      k++;
    end
    chk("done_seen", 128'(done_n != 0), 128'd1);
  endtask

  // Expected words: flatten accepted bytes, then cut into 8-byte words.
  task automatic build_exp();
    logic [7:0] by[$];
    int rem = int'(job_total);
    exp_q.delete();
    foreach (beats_q[i]) begin
      int n = beats_q[i].g;
      if (n > 8) n = 8;
      if (n > rem) n = rem;
      for (int k = 0; k < n; k++) by.push_back(beats_q[i].d[8*k +: 8]);
      rem -= n;
    end
    for (int w = 0; w * 8 < by.size(); w++) begin
      wr_t x;
      x.a = job_base + 18'(w);
      x.d = '0;
      x.m = '0;
      for (int k = 0; k < 8 && w * 8 + k < by.size(); k++) begin
        x.d[8*k +: 8] = by[w*8+k];
        x.m[k] = 1'b1;
      end
      exp_q.push_back(x);
    end
  endtask

  task automatic compare_job(string tag);
    build_exp();
    chk({tag, "_nwr"}, 128'(obs_q.size()), 128'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      chk({tag, "_wr"}, 128'(obs_q[i]), 128'(exp_q[i]));
    if (obs_c.size() > 0)
      chk({tag, "_done_lat"}, 128'(done_cyc), 128'(obs_c[obs_c.size()-1] + 1));
    chk({tag, "_done_n"}, 128'(done_n), 128'd1);
  endtask

  initial begin
    int b1, sc, acc, g;
    logic [63:0] d;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", outs(), 128'd0);
    rst = 1'b0;
    step();

    // full beats, exact fill
    start_job(18'h100, 18'd16);
    chk("full_busy", 128'(busy), 128'd1);
    b1 = cyc;
    send(8, 64'h0706050403020100);
    send(8, 64'h0F0E0D0C0B0A0908);
    wait_done(50);
    compare_job("full");
    if (obs_q.size() > 1) begin
      chk("full_lat", 128'(obs_c[0]), 128'(b1 + 1));
      chk("full_w1", 128'(obs_q[1]),
          128'({18'h101, 64'h0F0E0D0C0B0A0908, 8'hFF}));
    end
    step();
    chk("full_busy_low", 128'(busy), 128'd0);

    // straddling beats, garbage in unused lanes
    start_job(18'h20, 18'd10);
    for (int k = 0; k < 4; k++)
      send(3, {40'hEEEEEEEEEE, 8'(3*k+3), 8'(3*k+2), 8'(3*k+1)});
    wait_done(50);
    compare_job("strad");
    if (obs_q.size() > 1)
      chk("strad_tail", 128'(obs_q[1]),
          128'({18'h21, 64'h0A09, 8'h03}));

    // backpressure with address wrap
    sram_wr_ready = 1'b0;
    start_job(18'h3FFFA, 18'd96);
    for (int k = 0; k < 12; k++) send(8, {$urandom, $urandom});
    repeat (7) step();
    chk("bp_nowr", 128'(obs_q.size()), 128'd0);
    chk("bp_en", 128'(sram_wr_en), 128'd1);
    sram_wr_ready = 1'b1;
    wait_done(100);
    compare_job("bp");
    chk("bp_ovf", 128'(overflow), 128'd0);

    // overrun
    sram_wr_ready = 1'b0;
    start_job(18'h200, 18'd136);
    for (int k = 0; k < 16; k++) send(8, {$urandom, $urandom});
    chk("ovr_pre", 128'(overflow), 128'd0);
    send(8, {$urandom, $urandom});
    chk("ovr_set", 128'(overflow), 128'd1);
    repeat (2) step();
    sram_wr_ready = 1'b1;
    wait_done(100);
    build_exp();
    chk("ovr_nwr", 128'(obs_q.size()), 128'd16);
    for (int i = 0; i < 16 && i < obs_q.size(); i++)
      chk("ovr_wr", 128'(obs_q[i]), 128'(exp_q[i]));
    chk("ovr_sticky", 128'(overflow), 128'd1);

    // zero-length job
    sc = cyc;
    start_job(18'h55, 18'd0);
    chk("zero_ovf_clr", 128'(overflow), 128'd0);
    wait_done(10);
    chk("zero_done_lat", 128'(done_cyc), 128'(sc + 2));
    chk("zero_nwr", 128'(obs_q.size()), 128'd0);

    // empty beats and start while busy
    start_job(18'h300, 18'd8);
    for (int k = 0; k < 3; k++) send(0, {$urandom, $urandom});
    chk("g0_en", 128'(sram_wr_en), 128'd0);
    chk("g0_nwr", 128'(obs_q.size()), 128'd0);
    start = 1'b1;
    base_addr = 18'h999;
    total_elems = 18'd3;
    step();
    start = 1'b0;
    send(5, {$urandom, $urandom});
    send(5, {$urandom, $urandom});
    wait_done(50);
    compare_job("g0");

    // randomized jobs with random ready
    rdy_rand = 1;
    for (int j = 0; j < 6; j++) begin
      start_job(18'($urandom), 18'($urandom_range(1, 40)));
      acc = 0;
      while (acc < int'(job_total)) begin
        g = $urandom_range(0, 11);
        d = {$urandom, $urandom};
        send(g, d);
        acc += (g > 8) ? 8 : g;
        if ($urandom_range(0, 3) == 0) step();
      end
      repeat ($urandom_range(0, 2)) send($urandom_range(1, 8), {$urandom, $urandom});
      wait_done(500);
      compare_job("rnd");
    end
    rdy_rand = 0;
    sram_wr_ready = 1'b1;
    step();

    // async reset mid-job
    sram_wr_ready = 1'b0;
    start_job(18'h40, 18'd32);
    for (int k = 0; k < 4; k++) send(8, {$urandom, $urandom});
    sram_wr_ready = 1'b1;
    step();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_outs", outs(), 128'd0);
    chk("rst_one_wr", 128'(obs_q.size()), 128'd1);
    repeat (5) step();
    rst = 1'b0;
    repeat (3) step();
    chk("rst_no_more", 128'(obs_q.size()), 128'd1);
    start_job(18'h77, 18'd20);
    for (int k = 0; k < 3; k++) send(8, {$urandom, $urandom});
    wait_done(50);
    compare_job("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/requant_result_writer.md
# requant_result_writer

Output-side consumer of the GEMM engine's requantized result stream. Each beat carries `in_num_groups` signed int8 lanes alongside `in_valid`. The block packs the valid bytes densely into `SRAM_WIDTH`-bit words and buffers them in a small FIFO. It writes the words sequentially to output SRAM starting at a programmed base address, and signals completion once a programmed element count has been stored.

## Interface
- `DATA_WIDTH`, 8: bits per result element.
- `LANES`, 8: result lanes per input beat.
- `SRAM_WIDTH`, 64: output SRAM word width; `BPW` = `SRAM_WIDTH/DATA_WIDTH` bytes per word (8).
- `ADDR_WIDTH`, 18: SRAM word-address and element-count width.
- `FIFO_DEPTH`, 16: word FIFO entries, power of 2.
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: asynchronous active-high reset.
- `start` in 1: one-cycle pulse; samples `base_addr`/`total_elems`.
- `base_addr` in `ADDR_WIDTH`: first SRAM word address.
- `total_elems` in `ADDR_WIDTH`: number of bytes to store.
- `in_valid` in 1: result beat valid; there is no ready, so every beat is accepted.
- `in_data` in `LANES*DATA_WIDTH`: lane k at bits [8k+7:8k].
- `in_num_groups` in `$clog2(LANES+1)`: valid lanes 0..n-1 in this beat.
- `sram_wr_en` out 1: write request.
- `sram_wr_ready` in 1: SRAM accepts the write when high with `sram_wr_en`.
- `sram_wr_addr` out `ADDR_WIDTH`: word address.
- `sram_wr_data` out `SRAM_WIDTH`: packed word; byte 0 at LSB.
- `sram_wr_mask` out `BPW`: byte enables.
- `busy` out 1: job active.
- `done` out 1: one-cycle completion pulse.
- `overflow` out 1: sticky flag, set on FIFO overrun.

## Operation
- **FSM states:** IDLE, RUN, FLUSH, DRAIN.
- **IDLE**
  - `start` loads `addr`=`base_addr`, `remaining`=`total_elems`, clears the pack buffer and `overflow`, then goes to RUN.
  - If `total_elems`==0, go straight to DRAIN.
  - `in_valid` is ignored.
- **RUN: beat acceptance**
  - Each `in_valid` beat takes n = min(`in_num_groups`, `LANES`, `remaining`) bytes.
  - Bytes are appended in lane order to a 2·`BPW`-byte pack buffer at the current fill level; fill ≤ `BPW`-1 between beats.
  - n=0 is a no-op. Bytes beyond `remaining` are discarded.
- **RUN: word emission**
  - When fill ≥ `BPW`, the low `BPW` bytes are pushed to the FIFO with mask all-ones, and the buffer shifts down by `BPW`.
  - At most one push per cycle is sufficient, since n ≤ `BPW`.
- **RUN exit:** when `remaining` reaches 0, go to FLUSH.
- **FLUSH (one cycle)**
  - If fill > 0, push the partial word, zero-padded, with `mask[i]` = (i < fill).
  - Go to DRAIN.
- **DRAIN**
  - Wait until the FIFO is empty and no write is pending.
  - Then pulse `done`, drop `busy`, and return to IDLE.
- **`start` while `busy`:** ignored.
- **Write side**
  - The FIFO is first-word-fall-through, so `sram_wr_en` = !fifo_empty and the data/mask come from the head entry.
  - On `sram_wr_en` && `sram_wr_ready`: pop the entry, and `addr` increments by 1, wrapping modulo 2^`ADDR_WIDTH`.
- **Overflow**
  - Applies when a push is required while the FIFO is full.
  - If a pop occurs in the same cycle, push and pop both proceed and there is no overflow.
  - Otherwise the word is dropped and `overflow` is set. It stays set until the next accepted `start` or `rst`.
- **Reset:** `rst` mid-job aborts everything; the FIFO is emptied and there are no further writes.

## Timing
- **Reset values:** `sram_wr_en`=0, `sram_wr_addr`=0, `sram_wr_data`=0, `sram_wr_mask`=0, `busy`=0, `done`=0, `overflow`=0; FSM=IDLE.
- **`busy`:** high from the cycle after `start` through the cycle `done` pulses.
- **Write latency:** a beat that completes a word in cycle N gives `sram_wr_en`=1 in cycle N+1, given an empty FIFO.
- **Sustained rate:** with `sram_wr_ready` held at 1, one word is written per cycle.
- **Flush latency:** the partial word is pushed in the FLUSH cycle and written 1 cycle later at the earliest.
- **`done`:** asserted in the cycle after the final write handshake, or 2 cycles after `start` when `total_elems`=0.
- **Stable outputs:** `sram_wr_addr`/`data`/`mask` hold stable while `sram_wr_en` && !`sram_wr_ready`.
- **Same-cycle push/pop:** push and pop in one cycle leave the FIFO count unchanged.

## Test plan
- **Full beats, exact fill:** `start` with `base_addr`=0x100, `total_elems`=16; two beats of 8 lanes, bytes 0x00..0x0F.
  - Two writes: addr 0x100 data 0x0706050403020100, addr 0x101 data 0x0F0E0D0C0B0A0908, mask 0xFF both.
  - `done` one cycle after the second write.
- **Straddling beats:** `total_elems`=10; beats of 3,3,3,3 lanes, values 1..12.
  - Word 0 = bytes 1..8, mask 0xFF.
  - Flush word = bytes 9,10 then zeros, mask 0x03.
  - Bytes 11,12 are discarded.
- **Backpressure:** `sram_wr_ready` low for 20 cycles while 12 full beats arrive (`total_elems`=96, `FIFO_DEPTH`=16).
  - 12 writes in order once ready rises, addresses base..base+11.
  - `overflow`=0.
- **Overrun:** `sram_wr_ready` held low, 17 full beats (`total_elems`=136).
  - `overflow` rises when the 17th word is pushed.
  - Exactly 16 words are written after ready rises.
- **Corner cases**
  - `total_elems`=0 gives `done` with no `sram_wr_en`.
  - `in_num_groups`=0 beats leave `sram_wr_en` low.
  - `start` during `busy` changes nothing.
- **Async reset mid-job:** `rst` asserted after 1 of 4 words is written.
  - All outputs go to 0 immediately, and no further writes occur.
  - A fresh `start` runs correctly from `base_addr`.
